// File: rtl/uart_rx_wb_if.sv
// Data-bus slave port shared by the memory-mapped peripherals.
interface uart_rx_wb_if;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic [3:0]  wb_dbus_sel;
  logic        wb_dbus_we;
  logic        wb_dbus_cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (
    output wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    input  rdt, ack
  );

  modport slave (
    input  wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    output rdt, ack
  );
endinterface

// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver with a small byte FIFO, read through the data bus.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle, waiting for rxs low
// S_START | counting to mid start bit, reject it if the line went back high
// S_DATA  | sampling 8 data bits, LSB first, one per DIVIDE clocks
// S_STOP  | sampling the stop bit; high pushes the byte, low is a framing error
// S_BRK   | line held low after a framing error, wait for it to return high
module uart_rx_wb #(
  parameter logic [31:0] ADDR       = 32'h70,
  parameter int          AWIDTH     = 8,
  parameter int          DIVIDE     = 8,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic           wb_clk,
  input  logic           wb_rst,
  uart_rx_wb_if.slave    bus,
  input  logic           rx,
  output logic           irq
);
  localparam int CW    = $clog2(DIVIDE);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] HALF = CW'(DIVIDE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            rx_meta;
  logic            rxs;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic                  frame_err;

  logic full, not_empty, match, req, pop, push, do_push, frame_bad, st_wr;
  logic [7:0]  head;
  logic [31:0] rd_mux;
  logic        unused;

  assign unused = &{1'b0, bus.wb_dbus_sel, bus.wb_dbus_adr[31-AWIDTH:4],
                    bus.wb_dbus_adr[1:0], bus.wb_dbus_dat[31:4], bus.wb_dbus_dat[1:0]};

  assign full      = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign not_empty = (count != '0);
  assign irq       = not_empty;
  assign head      = not_empty ? mem[rptr] : 8'h00;

  // The stop-bit sample instant: push and framing error act on this same edge
  // so the byte is visible the cycle after the sample.
  assign push      = (state == S_STOP) && (cnt == LAST) && rxs;
  assign frame_bad = (state == S_STOP) && (cnt == LAST) && !rxs;

  assign match   = (bus.wb_dbus_adr[31 -: AWIDTH] == ADDR[AWIDTH-1:0]);
  assign req     = bus.wb_dbus_cyc && match && !bus.ack;
  assign pop     = req && !bus.wb_dbus_we && (bus.wb_dbus_adr[3:2] == 2'd0) && not_empty;
  assign st_wr   = req && bus.wb_dbus_we && (bus.wb_dbus_adr[3:2] == 2'd1);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign do_push = push && (!full || pop);

  always_comb begin
    rd_mux = 32'h0;
    case (bus.wb_dbus_adr[3:2])
      2'd0:    rd_mux = {24'h0, head};
      2'd1:    rd_mux = {28'h0, overrun, frame_err, full, not_empty};
      default: rd_mux = 32'h0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous rx pin, idling high.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver FSM: bit timing, start validation and shifting.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= rxs ? S_IDLE : S_BRK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BRK: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge wb_clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  // FIFO pointers, error flags (set beats clear) and the one-cycle bus ack.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      bus.ack   <= 1'b0;
      bus.rdt   <= 32'h0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun   <= (push && full && !pop) ||
                   (overrun && !(st_wr && bus.wb_dbus_dat[3]));
      frame_err <= frame_bad || (frame_err && !(st_wr && bus.wb_dbus_dat[2]));
      bus.ack   <= req;
      bus.rdt   <= (req && !bus.wb_dbus_we) ? rd_mux : 32'h0;
    end
  end
endmodule

// File: doc/uart_rx_wb.md
# uart_rx_wb

Wishbone-mapped 8N1 UART receiver: the receive-side companion to the SoC's `uart_tx`. It oversamples the asynchronous `rx` pin, validates start and stop bits, and buffers received bytes in a small FIFO. The CPU data bus reads bytes and status through a one-cycle-ack slave port. The block sits alongside the gpio, spi and uart_tx slaves, and its `rdt` is OR-ed into `wb_xbus_rdt`.

## Interface
- `ADDR`, 8'h70: match value for `wb_dbus_adr[31:31-AWIDTH+1]`.
- `AWIDTH`, 8: number of upper address bits decoded.
- `DIVIDE`, 8: `wb_clk` cycles per bit. Must be even and ≥4.
- `DEPTH_LOG2`, 2: FIFO depth is 2**DEPTH_LOG2 bytes.

Ports:
- `wb_clk`, in, 1: the only clock.
- `wb_rst`, in, 1: synchronous, active-low reset.
- `wb_dbus_adr`, in, 32: bus address. Bits [3:2] select the register.
- `wb_dbus_dat`, in, 32: write data.
- `wb_dbus_sel`, in, 4: byte selects. Ignored.
- `wb_dbus_we`, in, 1: write enable.
- `wb_dbus_cyc`, in, 1: bus cycle active.
- `rdt`, out, 32: read data. Zero whenever `ack` is low.
- `ack`, out, 1: one-cycle bus acknowledge.
- `rx`, in, 1: asynchronous serial input. Idle level is high.
- `irq`, out, 1: high while the FIFO is non-empty.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, giving `rxs`. Both flops reset to 1.
- **Receiver FSM:** states IDLE, START, DATA, STOP, BREAK. One counter `cnt` spans 0..DIVIDE-1. A 3-bit bit index and an 8-bit shift register complete the datapath.
  - IDLE: `rxs`=0 → START, with `cnt` loaded to 0.
  - START: at `cnt`=DIVIDE/2-1, sample `rxs`. If it is 0, go to DATA with `cnt`=0. If it is 1, treat it as a glitch and return to IDLE.
  - DATA: at `cnt`=DIVIDE-1, shift `rxs` into the MSB (the line is LSB first). After the 8th bit, go to STOP.
  - STOP: at `cnt`=DIVIDE-1, sample `rxs`.
    - If 1: push the byte and go to IDLE. A new start edge is accepted on the very next cycle.
    - If 0: set `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A held-low line therefore produces exactly one framing error.
- **FIFO:** circular buffer with read and write pointers and a count.
  - Push when full: set `overrun` and drop the new byte. Stored bytes are unchanged.
  - Push and pop in the same cycle: both take effect and the count is unchanged.
- **Registers:** selected by `wb_dbus_adr[3:2]`, only when the address matches.
  - 0 DATA, read: returns {24'h0, head byte} and pops the FIFO on the ack cycle. Reading while empty returns 0 and does not pop. Writes are ignored.
  - 1 STATUS, read: returns {28'h0, overrun, frame_err, full, not_empty}. A write with `dat[3]` set clears `overrun`; a write with `dat[2]` set clears `frame_err`.
  - 2, 3: read as 0, writes ignored, still acknowledged.
- If an error flag's set and clear happen in the same cycle, set wins.

## Timing
- **Ack:** `ack <= cyc & match & ~ack`.
  - `ack` is high for exactly one cycle, the cycle after `cyc` is first seen with a matching address.
  - `rdt` and all side effects (pop, flag clear) apply in the ack cycle.
  - The master drops `cyc` after `ack`. If `cyc` is held, `ack` toggles on alternate cycles.
- **Reset (`wb_rst`=0 at an edge):** `ack`=0, `rdt`=0, `irq`=0, FIFO empty, both flags 0, FSM in IDLE, synchronizer at 1. This applies mid-frame too: any partial byte is discarded.
- **Sample instants:** let t0 be the first cycle with `rxs`=0 while in IDLE (2 cycles after the `rx` edge).
  - Start check: t0+DIVIDE/2.
  - Data bit i (i = 0..7): t0+DIVIDE/2+(i+1)·DIVIDE.
  - Stop bit: t0+DIVIDE/2+9·DIVIDE.
- **Push visibility:** `irq` and `not_empty` rise the cycle after the stop sample.
- **Baud tolerance:** about ±4% total mismatch at DIVIDE=8; back-to-back frames are supported.

## Test plan
All scenarios use DIVIDE=8 and ADDR=8'h70. Bit time is 8 clocks.
- **Reset and idle:** after reset with `rx`=1, `irq`=0; a STATUS read at 0x7000_0004 returns 0 with `ack` high for one cycle.
- **Single byte:** send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → `irq` rises exactly 79 cycles after the `rx` falling edge (2 + 4 + 9·8, plus 1). A DATA read returns 0x0000_00A5, then `irq`=0.
- **Glitch rejection:** `rx` low for 3 cycles, then high → no byte, no flags, FSM back in IDLE. A valid 0x3C sent afterwards is received correctly.
- **Framing error and break:** send 0x55 with the stop bit 0, then hold `rx` low for 40 bit-times → STATUS=0x4 exactly once and the FIFO is empty. After `rx` returns high, 0x12 is received. Writing 0x4 to STATUS clears the flag.
- **Overrun and wrap:** send 5 back-to-back bytes 0x01..0x05 → STATUS=0xB (overrun, full, not_empty). Reads return 0x01..0x04, then the next read returns 0. Further bytes 0x06 and 0x07 read back correctly across the pointer wrap.
- **Simultaneous events:**
  - Pop in the same cycle a byte is pushed into a full FIFO: count is unchanged, no overrun, order is preserved.
  - Assert `wb_rst` low mid-frame: FIFO empty, and the next full frame is received correctly.
